div_pipelined: RTL and testbench

//  Multi-cycle unsigned restoring divider: quotient = I1 / I2, remainder = I1 % I2.
//  It is the inverse companion to the chunked add/sub ALU, with the same WIDTH/LATENCY

---
 rtl/div_pipelined_pkg.sv | 30 +++
 rtl/div_pipelined_if.sv | 24 ++
 rtl/div_pipelined_div_step.sv | 19 +
 rtl/div_pipelined.sv | 133 +++++++++++++
 tb/tb_div_pipelined.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/div_pipelined_pkg.sv
// Shared chunking helpers and FSM encoding for the multi-cycle divider.
// The ALU uses the same ceil-div chunking so both blocks resolve bits alike.
package div_pipelined_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    // Latency is clamped to [1, width]; asking for more clocks than bits buys nothing.
    function automatic int eff_latency(input int width, input int latency);
        if (latency < 1)     return 1;
        if (latency > width) return width;
        return latency;
    endfunction

    function automatic int calc_bpc(input int width, input int latency);
        return ceil_div(width, eff_latency(width, latency));
    endfunction

    function automatic int calc_steps(input int width, input int latency);
        return ceil_div(width, calc_bpc(width, latency));
    endfunction

endpackage

// File: rtl/div_pipelined_if.sv
// Operand/result handshake bundle between a producer/consumer and the divider.
interface div_pipelined_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] I1;
    logic [WIDTH-1:0] I2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output in_valid, I1, I2, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, I1, I2, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/div_pipelined_div_step.sv
// One restoring-division step: shift in a dividend bit, compare, conditionally subtract.
module div_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] r_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] r_o,
    output logic             q_o
);
    logic [WIDTH:0] shifted;

    // Incoming remainder is always < divisor, so it fits WIDTH bits; the WIDTH+1 bit
    // shifted value covers the compare, and the result again fits WIDTH bits.
    assign shifted = {r_i, bit_i};
    assign q_o     = (shifted >= {1'b0, d_i});
    assign r_o     = q_o ? WIDTH'(shifted - {1'b0, d_i}) : shifted[WIDTH-1:0];

endmodule

// File: rtl/div_pipelined.sv
// Multi-cycle unsigned restoring divider, BPC quotient bits resolved per BUSY clock.
module div_pipelined
    import div_pipelined_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int LATENCY = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    div_pipelined_if.slave bus
);
    localparam int BPC   = calc_bpc(WIDTH, LATENCY);
    localparam int STEPS = calc_steps(WIDTH, LATENCY);
    localparam int PAD   = STEPS * BPC;
    localparam int CNT_W = $clog2(STEPS + 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PAD-1:0]   dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] qout_q, qout_d;
    logic [WIDTH-1:0] rout_q, rout_d;
    logic             dbz_q, dbz_d;

    logic [BPC:0][WIDTH-1:0] r_chain;
    logic [BPC-1:0]          q_bits;
    logic                    dbz_now;
    logic                    last_step;

    assign dbz_now   = (dvs_q == '0);
    assign last_step = (cnt_q == CNT_W'(STEPS - 1));

    // Dividend bits feed the chain MSB first; the first step's quotient bit is the chunk MSB.
    assign r_chain[0] = rem_q;
    for (genvar j = 0; j < BPC; j++) begin : g_step
        div_step #(.WIDTH(WIDTH)) u_step (
            .r_i   (r_chain[j]),
            .bit_i (dvd_q[PAD-1-j]),
            .d_i   (dvs_q),
            .r_o   (r_chain[j+1]),
            .q_o   (q_bits[BPC-1-j])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (bus.in_valid)           state_d = ST_BUSY;
            ST_BUSY: if (dbz_now || last_step)   state_d = ST_DONE;
            ST_DONE: if (bus.out_ready)          state_d = ST_IDLE;
            default:                             state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready    = (state_q == ST_IDLE);
        bus.out_valid   = (state_q == ST_DONE);
        bus.quotient    = qout_q;
        bus.remainder   = rout_q;
        bus.div_by_zero = dbz_q;
    end

    always_comb begin
        cnt_d  = cnt_q;
        dvd_d  = dvd_q;
        dvs_d  = dvs_q;
        rem_d  = rem_q;
        quo_d  = quo_q;
        qout_d = qout_q;
        rout_d = rout_q;
        dbz_d  = dbz_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    dvd_d = PAD'(bus.I1);
                    dvs_d = bus.I2;
                    rem_d = '0;
                    quo_d = '0;
                    cnt_d = '0;
                end
            end
            ST_BUSY: begin
                if (dbz_now) begin
                    qout_d = '1;
                    rout_d = dvd_q[WIDTH-1:0];
                    dbz_d  = 1'b1;
                end else begin
                    dvd_d = dvd_q << BPC;
                    rem_d = r_chain[BPC];
                    // Leading quotient bits from zero padding fall off the top here.
                    quo_d = WIDTH'({quo_q, q_bits});
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last_step) begin
                        qout_d = WIDTH'({quo_q, q_bits});
                        rout_d = r_chain[BPC];
                        dbz_d  = 1'b0;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            dvd_q  <= '0;
            dvs_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            qout_q <= '0;
            rout_q <= '0;
            dbz_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            dvd_q  <= dvd_d;
            dvs_q  <= dvs_d;
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            qout_q <= qout_d;
            rout_q <= rout_d;
            dbz_q  <= dbz_d;
        end
    end

endmodule

// File: tb/tb_div_pipelined.sv
// Bench for div_pipelined: vector table, handshake/reset corners, random sweep vs / and %.
module tb_div_pipelined;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    div_pipelined_if #(.WIDTH(8)) if8 ();
    div_pipelined_if #(.WIDTH(7)) if7 ();

    div_pipelined #(.WIDTH(8), .LATENCY(4)) u_div8 (.clk(clk), .rst_n(rst_n), .bus(if8));
    div_pipelined #(.WIDTH(7), .LATENCY(3)) u_div7 (.clk(clk), .rst_n(rst_n), .bus(if7));

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int a, b, q, r, z, lat;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // sel=0 drives the 8-bit DUT, sel=1 the 7-bit one.
    task automatic set_in(input int sel, input bit v, input int a, input int b);
        if (sel == 1) begin
            if7.in_valid = v; if7.I1 = 7'(a); if7.I2 = 7'(b);
        end else begin
            if8.in_valid = v; if8.I1 = 8'(a); if8.I2 = 8'(b);
        end
    endtask

    task automatic set_ordy(input int sel, input bit v);
        if (sel == 1) if7.out_ready = v;
        else          if8.out_ready = v;
    endtask

    function automatic bit get_ov(input int sel);
        return (sel == 1) ? if7.out_valid : if8.out_valid;
    endfunction

    function automatic bit get_ir(input int sel);
        return (sel == 1) ? if7.in_ready : if8.in_ready;
    endfunction

    function automatic int get_q(input int sel);
        return (sel == 1) ? int'(if7.quotient) : int'(if8.quotient);
    endfunction

    function automatic int get_r(input int sel);
        return (sel == 1) ? int'(if7.remainder) : int'(if8.remainder);
    endfunction

    function automatic int get_z(input int sel);
        return (sel == 1) ? int'(if7.div_by_zero) : int'(if8.div_by_zero);
    endfunction

    // Reference: plain arithmetic plus the divide-by-zero convention.
    task automatic ref_div(input int w, input int a, input int b,
                           output int q, output int r, output int z);
        int mask;
        mask = (1 << w) - 1;
        if (b == 0) begin q = mask; r = a; z = 1; end
        else        begin q = a / b; r = a % b; z = 0; end
    endtask

    // Issue one operation, wait for the result, then complete the output handshake.
    task automatic run_op(input int sel, input int a, input int b,
                          output int q, output int r, output int z, output int lat);
        int n;
        n = 0;
        while (!get_ir(sel) && n < 50) begin @(posedge clk); #1; n++; end
        chk("in_ready_before_op", get_ir(sel), 1);
        set_in(sel, 1'b1, a, b);
        @(posedge clk); #1;
        set_in(sel, 1'b0, $urandom, $urandom);
        n = 0;
        while (!get_ov(sel) && n < 50) begin @(posedge clk); #1; n++; end
        lat = n;
        q = get_q(sel); r = get_r(sel); z = get_z(sel);
        set_ordy(sel, 1'b1);
        @(posedge clk); #1;
        set_ordy(sel, 1'b0);
        chk("out_valid_after_accept", get_ov(sel), 0);
        chk("in_ready_after_accept", get_ir(sel), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[$];
        int q, r, z, lat, eq, er, ez;
        int hq, hr, hz;

        vecs.push_back('{100,   7,  14,   2, 0, 4});
        vecs.push_back('{255,   1, 255,   0, 0, 4});
        vecs.push_back('{  5,   9,   0,   5, 0, 4});
        vecs.push_back('{  0,   3,   0,   0, 0, 4});
        vecs.push_back('{ 42,   0, 255,  42, 1, 1});
        vecs.push_back('{200, 200,   1,   0, 0, 4});
        vecs.push_back('{  1, 255,   0,   1, 0, 4});
        vecs.push_back('{255,   0, 255, 255, 1, 1});

        set_in(0, 1'b0, 0, 0); set_in(1, 1'b0, 0, 0);
        set_ordy(0, 1'b0); set_ordy(1, 1'b0);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", if8.in_ready, 1);
        chk("rst_out_valid", if8.out_valid, 0);
        chk("rst_quotient", if8.quotient, 0);
        chk("rst_remainder", if8.remainder, 0);
        chk("rst_dbz", if8.div_by_zero, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            run_op(0, vecs[i].a, vecs[i].b, q, r, z, lat);
            chk($sformatf("vec%0d_q", i), q, vecs[i].q);
            chk($sformatf("vec%0d_r", i), r, vecs[i].r);
            chk($sformatf("vec%0d_dbz", i), z, vecs[i].z);
            chk($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
        end

        // Hold the result with out_ready low while a new request knocks.
        set_in(0, 1'b1, 200, 13);
        @(posedge clk); #1;
        set_in(0, 1'b0, 0, 0);
        repeat (4) @(posedge clk);
        #1;
        chk("hold_ov_rise", if8.out_valid, 1);
        hq = if8.quotient; hr = if8.remainder; hz = if8.div_by_zero;
        chk("hold_q", hq, 15);
        chk("hold_r", hr, 5);
        set_in(0, 1'b1, 9, 2);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            chk("hold_stable", {if8.out_valid, if8.in_ready, if8.quotient, if8.remainder,
                                if8.div_by_zero}, {1'b1, 1'b0, 8'(hq), 8'(hr), 1'(hz)});
        end
        set_in(0, 1'b0, 0, 0);
        set_ordy(0, 1'b1);
        @(posedge clk); #1;
        set_ordy(0, 1'b0);
        chk("hold_release_ov", if8.out_valid, 0);
        chk("hold_release_ir", if8.in_ready, 1);
        @(posedge clk); #1;
        chk("hold_ignored_req", if8.in_ready, 1);
        run_op(0, 9, 2, q, r, z, lat);
        chk("after_hold_q", q, 4);
        chk("after_hold_r", r, 1);

        // Abort mid-BUSY with reset.
        set_in(0, 1'b1, 100, 7);
        @(posedge clk); #1;
        set_in(0, 1'b0, 0, 0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_ov", if8.out_valid, 0);
        chk("abort_ir", if8.in_ready, 1);
        chk("abort_q", if8.quotient, 0);
        chk("abort_r", if8.remainder, 0);
        chk("abort_dbz", if8.div_by_zero, 0);
        #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("abort_idle_after_release", {if8.in_ready, if8.out_valid}, 2'b10);
        run_op(0, 100, 7, q, r, z, lat);
        chk("post_abort_q", q, 14);
        chk("post_abort_r", r, 2);
        chk("post_abort_lat", lat, 4);

        // 7-bit instance: three iteration clocks, three bits each.
        run_op(1, 127, 3, q, r, z, lat);
        chk("w7_q", q, 42);
        chk("w7_r", r, 1);
        chk("w7_lat", lat, 3);
        run_op(1, 99, 0, q, r, z, lat);
        chk("w7_dbz_q", q, 127);
        chk("w7_dbz_r", r, 99);
        chk("w7_dbz_z", z, 1);

        for (int sel = 0; sel < 2; sel++) begin
            int w, a, b, nlat;
            w = (sel == 1) ? 7 : 8;
            nlat = (sel == 1) ? 3 : 4;
            for (int k = 0; k < 150; k++) begin
                a = $urandom_range((1 << w) - 1, 0);
                b = ($urandom_range(7, 0) == 0) ? 0 : $urandom_range((1 << w) - 1, 1);
                ref_div(w, a, b, eq, er, ez);
                run_op(sel, a, b, q, r, z, lat);
                chk($sformatf("rnd_w%0d_%0d/%0d_q", w, a, b), q, eq);
                chk($sformatf("rnd_w%0d_%0d/%0d_r", w, a, b), r, er);
                chk($sformatf("rnd_w%0d_%0d/%0d_dbz", w, a, b), z, ez);
                chk($sformatf("rnd_w%0d_%0d/%0d_lat", w, a, b), lat, (b == 0) ? 1 : nlat);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
